// File: rtl/note_recorder_pkg.sv
// Shared types and constants for the note recorder: key code width, the
// "no key" code, the recorder FSM states and the stored event layout.
package recorder_pkg;

    localparam int KEY_W = 6;
    localparam logic [KEY_W-1:0] NO_KEY = 6'd48;
    localparam int NUM_KEYS = 48;
    localparam int EV_DUR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REC,
        ST_PLAY_LOAD,
        ST_PLAY
    } rec_state_t;

    // Event layout at the default duration width; the top re-declares it
    // with its own DUR_W so narrower builds keep the same field order.
    typedef struct packed {
        logic [KEY_W-1:0]    code;
        logic [EV_DUR_W-1:0] dur;
    } event_t;

    function automatic logic is_key(input logic [KEY_W-1:0] code);
        return code < KEY_W'(NUM_KEYS);
    endfunction

endpackage

// File: rtl/note_recorder_event_ram.sv
// Simple dual-port event store: one synchronous write port, one registered
// read port, no reset so it maps onto block RAM.
module event_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data <= mem_q[rd_addr];
    end

endmodule

// File: rtl/note_recorder.sv
// Records the encoder's key stream as (code, duration) events and replays
// them as a 6-bit code stream for the tone generator.
module note_recorder
    import recorder_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int TICK_DIV = 500000,
    parameter int DUR_W    = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [KEY_W-1:0]           key_code,
    input  logic                       rec_req,
    input  logic                       play_req,
    input  logic                       stop_req,
    output logic [KEY_W-1:0]           play_code,
    output logic                       busy_rec,
    output logic                       busy_play,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] ev_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DUR_W-1:0] DUR_MAX    = '1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0]    CNT_LAST   = CW'(DEPTH - 1);

    typedef struct packed {
        logic [KEY_W-1:0] code;
        logic [DUR_W-1:0] dur;
    } ev_t;

    rec_state_t       state_q;
    logic [PW-1:0]    presc_q;
    logic [KEY_W-1:0] cur_code_q;
    logic [DUR_W-1:0] dur_q;
    logic [DUR_W-1:0] remain_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    ev_count_q;
    logic             full_q;
    logic             busy_rec_q;
    logic             busy_play_q;
    logic [KEY_W-1:0] play_code_q;

    logic tick;
    logic key_changed;
    logic wr_en;
    logic last_ev;
    ev_t  wr_ev;
    ev_t  rd_ev;

    // The saturation write stores dur_q, which already equals the max value.
    assign wr_ev = '{code: cur_code_q, dur: dur_q};

    always_comb begin
        tick        = (presc_q == PRESC_LAST);
        key_changed = (key_code != cur_code_q);
        wr_en       = (state_q == ST_REC) &&
                      (stop_req || key_changed || (tick && (dur_q == DUR_MAX)));
        last_ev     = ((CW'(rd_ptr_q) + CW'(1)) == ev_count_q);
        rd_ptr_d    = rd_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (!rec_req && play_req) begin
                    rd_ptr_d = '0;
                end
            end
            ST_PLAY: begin
                if (!stop_req && (remain_q == '0) && !last_ev) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

    // Reading from the next pointer lands the event in rd_ev by the end of PLAY_LOAD.
    event_ram #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_W + DUR_W),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ev_count_q[AW-1:0]),
        .wr_data (wr_ev),
        .rd_addr (rd_ptr_d),
        .rd_data (rd_ev)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            cur_code_q  <= NO_KEY;
            dur_q       <= '0;
            remain_q    <= '0;
            rd_ptr_q    <= '0;
            ev_count_q  <= '0;
            full_q      <= 1'b0;
            busy_rec_q  <= 1'b0;
            busy_play_q <= 1'b0;
            play_code_q <= NO_KEY;
        end else begin
            presc_q  <= tick ? '0 : presc_q + PW'(1);
            rd_ptr_q <= rd_ptr_d;
            if (wr_en) begin
                ev_count_q <= ev_count_q + CW'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (rec_req) begin
                        state_q    <= ST_REC;
                        busy_rec_q <= 1'b1;
                        ev_count_q <= '0;
                        full_q     <= 1'b0;
                        cur_code_q <= key_code;
                        dur_q      <= '0;
                        presc_q    <= '0;
                    end else if (play_req && (ev_count_q != '0)) begin
                        state_q     <= ST_PLAY_LOAD;
                        busy_play_q <= 1'b1;
                        presc_q     <= '0;
                    end
                end
                ST_REC: begin
                    if (stop_req) begin
                        state_q    <= ST_IDLE;
                        busy_rec_q <= 1'b0;
                    end else if (key_changed) begin
                        cur_code_q <= key_code;
                        dur_q      <= tick ? DUR_W'(1) : '0;
                    end else if (tick) begin
                        dur_q <= (dur_q == DUR_MAX) ? DUR_W'(1) : dur_q + DUR_W'(1);
                    end
                    if (wr_en && (ev_count_q == CNT_LAST)) begin
                        full_q     <= 1'b1;
                        state_q    <= ST_IDLE;
                        busy_rec_q <= 1'b0;
                    end
                end
                ST_PLAY_LOAD: begin
                    if (stop_req) begin
                        play_code_q <= NO_KEY;
                        state_q     <= ST_IDLE;
                        busy_play_q <= 1'b0;
                    end else begin
                        play_code_q <= rd_ev.code;
                        remain_q    <= rd_ev.dur;
                        state_q     <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (stop_req || ((remain_q == '0) && last_ev)) begin
                        play_code_q <= NO_KEY;
                        state_q     <= ST_IDLE;
                        busy_play_q <= 1'b0;
                    end else if (remain_q == '0) begin
                        state_q <= ST_PLAY_LOAD;
                    end else if (tick) begin
                        remain_q <= remain_q - DUR_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign play_code = play_code_q;
    assign busy_rec  = busy_rec_q;
    assign busy_play = busy_play_q;
    assign full      = full_q;
    assign ev_count  = ev_count_q;

endmodule
